// File: rtl/pkt_operand_streamer.sv
// Packet-word to operand-pair streamer: 2-entry word FIFO, 16-pair serialiser, registered A_s/B_s output.
// Optional stall counter output enabled by defining STREAMER_STALL_CNT_EN.
//
//   state  | meaning
//   S_IDLE | after reset, waiting for start_i
//   S_RUN  | accepting words and issuing pairs
//   S_DONE | LENGTH pairs issued, buffers flushed, waiting for start_i
module pkt_operand_streamer #(
    parameter int WORD_W = 255,
    parameter int LENGTH = 2000,
    parameter int CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              pkt_valid_i,
    output logic              pkt_ready_o,
    input  logic [WORD_W-1:0] pkt_word_i,
    output logic [7:0]        A_s,
    output logic [7:0]        B_s,
    output logic              op_valid_o,
    input  logic              op_ready_i,
    output logic [CNT_W-1:0]  pair_cnt_o,
    output logic              done_o
`ifdef STREAMER_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt_o
`endif
);

    localparam int               SR_W     = WORD_W + 1;
    localparam logic [CNT_W-1:0] LEN_C    = CNT_W'(LENGTH);
    localparam bit               LEN_ZERO = (LENGTH == 0);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t state_q, state_d;

    logic [WORD_W-1:0] fifo_mem [2];
    logic              wr_ptr, rd_ptr;
    logic [1:0]        fifo_cnt;

    logic [SR_W-1:0]   sr_word;
    logic [3:0]        sr_idx;
    logic              sr_valid;

    logic run, push, pop, out_adv, hs, last_hs, sr_take, sr_last, flush;

    assign run         = (state_q == S_RUN);
    assign pkt_ready_o = run && (fifo_cnt < 2'd2);
    assign push        = pkt_valid_i && pkt_ready_o;
    assign out_adv     = !op_valid_o || op_ready_i;
    assign hs          = op_valid_o && op_ready_i;
    assign last_hs     = hs && ((pair_cnt_o + CNT_W'(1)) == LEN_C);
    assign flush       = start_i || last_hs;
    assign sr_last     = (sr_idx == 4'd15);
    assign sr_take     = run && sr_valid && out_adv && !last_hs;
    // Reload on the same edge the last pair moves out, so consecutive words have no bubble.
    assign pop         = run && !last_hs && (fifo_cnt != 2'd0) &&
                         (!sr_valid || (sr_take && sr_last));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start_i) state_d = LEN_ZERO ? S_DONE : S_RUN;
            S_RUN: begin
                if (start_i)      state_d = LEN_ZERO ? S_DONE : S_RUN;
                else if (last_hs) state_d = S_DONE;
            end
            S_DONE: if (start_i) state_d = LEN_ZERO ? S_DONE : S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            done_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_o  <= (state_d == S_DONE);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr] <= pkt_word_i;
    end

    // A word offered in the start_i cycle is kept as the first word of the new run.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
        end else if (start_i) begin
            rd_ptr   <= wr_ptr;
            wr_ptr   <= wr_ptr ^ push;
            fifo_cnt <= {1'b0, push};
        end else if (last_hs) begin
            rd_ptr   <= wr_ptr;
            fifo_cnt <= 2'd0;
        end else begin
            wr_ptr   <= wr_ptr ^ push;
            rd_ptr   <= rd_ptr ^ pop;
            fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sr_word  <= '0;
            sr_idx   <= 4'd0;
            sr_valid <= 1'b0;
        end else if (flush) begin
            sr_idx   <= 4'd0;
            sr_valid <= 1'b0;
        end else if (pop) begin
            sr_word  <= {1'b0, fifo_mem[rd_ptr]};
            sr_idx   <= 4'd0;
            sr_valid <= 1'b1;
        end else if (sr_take) begin
            sr_word  <= sr_word >> 16;
            sr_idx   <= sr_idx + 4'd1;
            if (sr_last) sr_valid <= 1'b0;
        end
    end

    // A_s/B_s keep their last values through underruns and after the run ends.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            A_s        <= 8'd0;
            B_s        <= 8'd0;
            op_valid_o <= 1'b0;
        end else if (flush) begin
            op_valid_o <= 1'b0;
        end else if (run && out_adv) begin
            op_valid_o <= sr_valid;
            if (sr_valid) begin
                A_s <= sr_word[7:0];
                B_s <= sr_word[15:8];
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)      pair_cnt_o <= '0;
        else if (start_i) pair_cnt_o <= '0;
        else if (hs)      pair_cnt_o <= pair_cnt_o + CNT_W'(1);
    end

`ifdef STREAMER_STALL_CNT_EN
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)      stall_cnt_o <= '0;
        else if (start_i) stall_cnt_o <= '0;
        else if (op_valid_o && !op_ready_i && (stall_cnt_o != '1))
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
`endif

endmodule

// File: tb/tb_pkt_operand_streamer.sv
// Self-checking bench for pkt_operand_streamer: directed scenarios plus randomized runs against a pair-queue model.
// Stall counter checks are included when STREAMER_STALL_CNT_EN is defined.
module tb_pkt_operand_streamer;

    localparam int WORD_W = 255;
    localparam int LEN    = 20;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              pkt_valid;
    logic              pkt_ready;
    logic [WORD_W-1:0] pkt_word;
    logic [7:0]        a_s, b_s;
    logic              op_valid;
    logic              op_ready;
    logic [CNT_W-1:0]  pair_cnt;
    logic              done;

    logic              z_start;
    logic              z_ready;
    logic [7:0]        z_a, z_b;
    logic              z_valid;
    logic [CNT_W-1:0]  z_pair_cnt;
    logic              z_done;
`ifdef STREAMER_STALL_CNT_EN
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  z_stall;
`endif

    always #5 clk = ~clk;

    pkt_operand_streamer #(.WORD_W(WORD_W), .LENGTH(LEN), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .reset_i(rst), .start_i(start),
        .pkt_valid_i(pkt_valid), .pkt_ready_o(pkt_ready), .pkt_word_i(pkt_word),
        .A_s(a_s), .B_s(b_s), .op_valid_o(op_valid), .op_ready_i(op_ready),
        .pair_cnt_o(pair_cnt), .done_o(done)
`ifdef STREAMER_STALL_CNT_EN
        , .stall_cnt_o(stall_cnt)
`endif
    );

    pkt_operand_streamer #(.WORD_W(WORD_W), .LENGTH(0), .CNT_W(CNT_W)) dut_zero (
        .clk_i(clk), .reset_i(rst), .start_i(z_start),
        .pkt_valid_i(1'b0), .pkt_ready_o(z_ready), .pkt_word_i('0),
        .A_s(z_a), .B_s(z_b), .op_valid_o(z_valid), .op_ready_i(1'b1),
        .pair_cnt_o(z_pair_cnt), .done_o(z_done)
`ifdef STREAMER_STALL_CNT_EN
        , .stall_cnt_o(z_stall)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0]       exp_q[$];
    logic [WORD_W-1:0] pend[$];
    int                exp_cnt;
    bit                exp_done;
    int                exp_stall;
    bit                feed_en;
    int                vld_pct;
    logic [15:0]       last_pair;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [WORD_W-1:0] w, input int k);
        if (k < 31) return w[8*k +: 8];
        return {1'b0, w[254:248]};
    endfunction

    function automatic logic [WORD_W-1:0] rand_word();
        logic [255:0] t;
        for (int i = 0; i < 8; i++) t[32*i +: 32] = $urandom;
        return t[254:0];
    endfunction

    function automatic logic [WORD_W-1:0] ramp_word();
        logic [WORD_W-1:0] w;
        w = '0;
        for (int k = 0; k < 31; k++) w[8*k +: 8] = 8'(k);
        w[254:248] = 7'd31;
        return w;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        pend.delete();
        exp_cnt   = 0;
        exp_done  = 1'b0;
        exp_stall = 0;
    endtask

    // One clock: drive at negedge, observe handshakes just before the edge, check 1ns after it.
    task automatic cyc(input bit st, input bit rdy);
        logic pre_hs, pre_push, pre_stall;
        logic [15:0] pre_pair;
        logic [WORD_W-1:0] pre_w;
        @(negedge clk);
        start     = st;
        op_ready  = rdy;
        pkt_valid = feed_en && (pend.size() > 0) && ($urandom_range(0, 99) < vld_pct);
        pkt_word  = (pend.size() > 0) ? pend[0] : rand_word();
        #1;
        pre_hs    = op_valid && op_ready;
        pre_push  = pkt_valid && pkt_ready;
        pre_stall = op_valid && !op_ready;
        pre_pair  = {a_s, b_s};
        pre_w     = pkt_word;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (pre_push) void'(pend.pop_front());
        if (st) begin
            exp_q.delete();
            exp_cnt   = 0;
            exp_done  = (LEN == 0);
            exp_stall = 0;
        end else begin
            if (pre_hs) begin
                check("pair_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("pair_value", pre_pair, exp_q.pop_front());
                last_pair = pre_pair;
                exp_cnt++;
                if (exp_cnt == LEN) begin
                    exp_done = 1'b1;
                    exp_q.delete();
                end
            end
            if (pre_stall) exp_stall++;
        end
        if (pre_push && !exp_done)
            for (int j = 0; j < 16; j++)
                exp_q.push_back({byte_of(pre_w, 2*j), byte_of(pre_w, 2*j + 1)});
        if (pre_stall && !st) check("stall_hold", {op_valid, a_s, b_s}, {1'b1, pre_pair});
        check("pair_cnt", pair_cnt, exp_cnt);
        check("done", done, exp_done);
        if (exp_done) check("valid_after_done", {op_valid, pkt_ready}, 2'b00);
`ifdef STREAMER_STALL_CNT_EN
        check("stall_cnt", stall_cnt, exp_stall);
`endif
    endtask

    initial begin
        logic [WORD_W-1:0] w_a, w_b, w_c;
        rst = 1'b1; start = 1'b0; pkt_valid = 1'b0; pkt_word = '0; op_ready = 1'b1;
        z_start = 1'b0; feed_en = 1'b1; vld_pct = 100; last_pair = '0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check("rst_outputs", {op_valid, a_s, b_s, pkt_ready, done}, '0);
        check("rst_pair_cnt", pair_cnt, 0);
`ifdef STREAMER_STALL_CNT_EN
        check("rst_stall_cnt", stall_cnt, 0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Zero-length run: done the cycle after start, nothing issued.
        @(negedge clk);
        z_start = 1'b1;
        @(posedge clk);
        #1;
        z_start = 1'b0;
        check("zero_done", z_done, 1);
        check("zero_outputs", {z_valid, z_ready, z_a, z_b}, '0);
        check("zero_pair_cnt", z_pair_cnt, 0);
`ifdef STREAMER_STALL_CNT_EN
        check("zero_stall", z_stall, 0);
`endif

        // 1: ramp word, latency and 16 consecutive pairs.
        cyc(1, 1);
        pend.push_back(ramp_word());
        cyc(0, 1);
        check("t1_pushed", pend.size(), 0);
        check("t1_lat_e0", op_valid, 0);
        cyc(0, 1);
        check("t1_lat_e1", op_valid, 0);
        cyc(0, 1);
        for (int i = 0; i < 16; i++) begin
            check("t1_stream", {op_valid, a_s, b_s}, {1'b1, 8'(2*i), 8'(2*i + 1)});
            cyc(0, 1);
        end
        check("t1_underrun", op_valid, 0);

        // 2: all-ones word, byte 31 padded.
        cyc(1, 1);
        pend.push_back('1);
        repeat (20) cyc(0, 1);
        check("t2_last_pair", last_pair, 16'hFF7F);

        // 3: stall three cycles on pair 5.
        cyc(1, 1);
        pend.push_back(ramp_word());
        for (int i = 0; i < 20 && !(op_valid && a_s == 8'h0A); i++) cyc(0, 1);
        check("t3_at_pair5", {op_valid, a_s, b_s}, {1'b1, 16'h0A0B});
        repeat (3) cyc(0, 0);
        check("t3_held", {op_valid, a_s, b_s}, {1'b1, 16'h0A0B});
        check("t3_pair_cnt", pair_cnt, 5);
`ifdef STREAMER_STALL_CNT_EN
        check("t3_stall_cnt", stall_cnt, 3);
`endif
        repeat (14) cyc(0, 1);

        // 4: three words back-to-back, run ends at 20 pairs.
        cyc(1, 1);
        w_a = rand_word(); w_b = rand_word(); w_c = rand_word();
        pend.push_back(w_a); pend.push_back(w_b); pend.push_back(w_c);
        for (int i = 0; i < 60 && !done; i++) cyc(0, 1);
        check("t4_done", done, 1);
        check("t4_last_pair", last_pair, {byte_of(w_b, 6), byte_of(w_b, 7)});
        repeat (5) cyc(0, 1);
        check("t4_idle", {op_valid, pkt_ready, done}, 3'b001);
        check("t4_count", pair_cnt, LEN);

        // 5: one word, idle gap, second word continues the count.
        cyc(1, 1);
        w_a = rand_word(); w_b = rand_word();
        pend.push_back(w_a);
        repeat (19) cyc(0, 1);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 1);
            check("t5_gap", {op_valid, a_s, b_s}, {1'b0, byte_of(w_a, 30), byte_of(w_a, 31)});
        end
        pend.push_back(w_b);
        for (int i = 0; i < 8 && pair_cnt != 17; i++) cyc(0, 1);
        check("t5_resume_cnt", pair_cnt, 17);
        check("t5_resume_pair", last_pair, {byte_of(w_b, 0), byte_of(w_b, 1)});

        // 6: asynchronous reset at pair 7, then restart.
        cyc(1, 1);
        pend.push_back(ramp_word());
        for (int i = 0; i < 20 && !(op_valid && a_s == 8'h0E); i++) cyc(0, 1);
        check("t6_at_pair7", {op_valid, a_s, b_s}, {1'b1, 16'h0E0F});
        #2 rst = 1'b1;
        #1;
        check("t6_rst_outputs", {op_valid, a_s, b_s, pkt_ready, done}, '0);
        check("t6_rst_pair_cnt", pair_cnt, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cyc(1, 1);
        w_c = rand_word();
        pend.push_back(w_c);
        for (int i = 0; i < 6 && !op_valid; i++) cyc(0, 1);
        check("t6_restart_pair", {op_valid, a_s, b_s}, {1'b1, byte_of(w_c, 0), byte_of(w_c, 1)});
        check("t6_restart_cnt", pair_cnt, 0);
        repeat (3) cyc(0, 1);

        // Randomized runs: random words, valid gaps and bfm stalls.
        vld_pct = 60;
        for (int r = 0; r < 8; r++) begin
            cyc(1, 1);
            for (int k = 0; k < 3; k++) pend.push_back(rand_word());
            for (int i = 0; i < 400 && !done; i++) cyc(0, $urandom_range(0, 99) < 70);
            check("rand_done", done, 1);
            pend.delete();
            repeat (3) cyc(0, $urandom_range(0, 1) == 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
